// File: rtl/mux_nch_reg.sv
// N-channel, W-bit registered multiplexer with valid/ready handshakes on every channel.
// Define MUX_RR_ARB_EN to replace the sel input with round-robin arbitration.
module mux_nch_reg #(
   parameter int unsigned WORD_SIZE = 10,
   parameter int unsigned NUM_CH    = 5,
   parameter int unsigned SEL_W     = 3
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_CH*WORD_SIZE-1:0] data_in,
   input  logic [NUM_CH-1:0]           in_valid,
   output logic [NUM_CH-1:0]           in_ready,
   input  logic [SEL_W-1:0]            sel,
   output logic [WORD_SIZE-1:0]        mux_out,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [SEL_W-1:0]            ch_out,
   output logic                        sel_err
);

   logic [WORD_SIZE-1:0] mux_out_q, mux_out_d;
   logic [SEL_W-1:0]     ch_out_q, ch_out_d;
   logic                 out_valid_q, out_valid_d;

   logic [SEL_W-1:0]     gnt;
   logic                 gnt_ok;     // gnt names a real channel that may be offered in_ready
   logic                 gnt_valid;
   logic [WORD_SIZE-1:0] gnt_data;
   logic                 load_ok;
   logic                 capture;

   assign load_ok = !out_valid_q || out_ready;

`ifdef MUX_RR_ARB_EN
   logic [SEL_W-1:0] last_gnt_q, last_gnt_d;
   int               dist;
   int               best_dist;
   logic             unused_sel;

   assign unused_sel = ^sel;
   assign sel_err    = 1'b0;

   // Pick the valid channel closest after last_gnt, walking upward modulo NUM_CH.
   always_comb begin
      gnt       = '0;
      gnt_ok    = 1'b0;
      best_dist = int'(NUM_CH);
      dist      = 0;
      for (int k = 0; k < int'(NUM_CH); k++) begin
         dist = (k + int'(NUM_CH) - 1 - int'(last_gnt_q)) % int'(NUM_CH);
         if (in_valid[k] && dist < best_dist) begin
            best_dist = dist;
            gnt       = SEL_W'(k);
            gnt_ok    = 1'b1;
         end
      end
   end

   assign last_gnt_d = capture ? gnt : last_gnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_gnt_q <= SEL_W'(NUM_CH - 1);
      end else begin
         last_gnt_q <= last_gnt_d;
      end
   end
`else
   logic sel_err_q;

   assign gnt    = sel;
   assign gnt_ok = {1'b0, sel} < (SEL_W + 1)'(NUM_CH);

   // Out-of-range select is re-registered every cycle, so it self-clears.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_err_q <= 1'b0;
      end else begin
         sel_err_q <= !gnt_ok;
      end
   end

   assign sel_err = sel_err_q;
`endif

   // Loop-based lookup keeps out-of-range grants from indexing past the channel vectors.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_data  = '0;
      for (int k = 0; k < int'(NUM_CH); k++) begin
         if (gnt_ok && gnt == SEL_W'(k)) begin
            gnt_valid = in_valid[k];
            gnt_data  = data_in[k*WORD_SIZE +: WORD_SIZE];
         end
      end
   end

   assign capture = load_ok && gnt_valid;

   always_comb begin
      in_ready = '0;
      for (int k = 0; k < int'(NUM_CH); k++) begin
         in_ready[k] = rst_n && load_ok && gnt_ok && (gnt == SEL_W'(k));
      end
   end

   always_comb begin
      mux_out_d   = mux_out_q;
      ch_out_d    = ch_out_q;
      out_valid_d = out_valid_q;
      if (capture) begin
         mux_out_d   = gnt_data;
         ch_out_d    = gnt;
         out_valid_d = 1'b1;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mux_out_q   <= '0;
         ch_out_q    <= '0;
         out_valid_q <= 1'b0;
      end else begin
         mux_out_q   <= mux_out_d;
         ch_out_q    <= ch_out_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign mux_out   = mux_out_q;
   assign ch_out    = ch_out_q;
   assign out_valid = out_valid_q;

endmodule
